// File: rtl/cic_interp_pdm.sv
// cic_interp_pdm: 3-stage CIC interpolator with gain shift and saturation,
// followed by a first-order delta-sigma modulator emitting one bit per clk.
module cic_interp_pdm #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 48
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     interpolation_ratio,
  input  logic [5:0]      gain_shift,
  input  logic [IN_W-1:0] s_data,
  input  logic            s_valid,
  output logic            s_ready,
  output logic            s_clk,
  output logic            pdm_out,
  output logic            underrun
);

  localparam int CW = IN_W + 3;
  localparam int EW = IN_W + 2;

  localparam logic signed [ACC_W-1:0] Y_MAX =
    ACC_W'(2 ** (IN_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN =
    ACC_W'(-(2 ** (IN_W - 1)));
  localparam logic signed [EW-1:0] FS_P =
    EW'(2 ** (IN_W - 1));
  localparam logic signed [EW-1:0] FS_N =
    EW'(-(2 ** (IN_W - 1)));

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] r_q, r_d;
  logic [5:0]  sh_q, sh_d;
  logic        cfg_q, cfg_d;
  logic        rdy_q, rdy_d;
  logic        sclk_q, sclk_d;
  logic        und_q, und_d;
  logic        cen_q, cen_d;
  logic        uen_q, uen_d;
  logic        pdm_q, pdm_d;

  logic signed [IN_W-1:0]  x_q, x_d;
  logic signed [CW-1:0]    xd_q, xd_d;
  logic signed [CW-1:0]    c1d_q, c1d_d;
  logic signed [CW-1:0]    c2d_q, c2d_d;
  logic signed [CW-1:0]    c3_q, c3_d;
  logic signed [ACC_W-1:0] i1_q, i1_d;
  logic signed [ACC_W-1:0] i2_q, i2_d;
  logic signed [ACC_W-1:0] i3_q, i3_d;
  logic signed [EW-1:0]    e_q, e_d;

  logic [15:0] r_live;
  logic [15:0] r_eff;
  logic [15:0] r_nxt;
  logic [5:0]  sh_eff;
  logic        wrap;

  logic signed [CW-1:0]    x_ext;
  logic signed [CW-1:0]    c1;
  logic signed [CW-1:0]    c2;
  logic signed [CW-1:0]    c3;
  logic signed [ACC_W-1:0] u;
  logic signed [ACC_W-1:0] ysh;
  logic signed [IN_W-1:0]  y;
  logic signed [EW-1:0]    y_ext;
  logic signed [EW-1:0]    fb;
  logic                    b;

  // Until the first wrap latches a config, the live inputs run frame 0.
  always_comb begin
    r_live = (interpolation_ratio < 16'd2) ?
             16'd2 : interpolation_ratio;
    r_eff  = cfg_q ? r_q : r_live;
    sh_eff = cfg_q ? sh_q : gain_shift;
    wrap   = rdy_q;
    r_d    = r_q;
    sh_d   = sh_q;
    cfg_d  = cfg_q;
    cnt_d  = cnt_q + 16'd1;
    r_nxt  = r_eff;
    if (wrap) begin
      cnt_d = '0;
      r_d   = r_live;
      sh_d  = gain_shift;
      cfg_d = 1'b1;
      r_nxt = r_live;
    end
    rdy_d  = (cnt_d == r_nxt - 16'd1);
    sclk_d = sclk_q;
    if (wrap) begin
      sclk_d = 1'b1;
    end else if (cnt_d == (r_eff >> 1)) begin
      sclk_d = 1'b0;
    end
  end

  always_comb begin
    x_d   = x_q;
    und_d = und_q;
    cen_d = wrap;
    if (wrap) begin
      if (s_valid) begin
        x_d = s_data;
      end else begin
        und_d = 1'b1;
      end
    end
    x_ext = {{(CW-IN_W){x_q[IN_W-1]}}, x_q};
    c1    = x_ext - xd_q;
    c2    = c1 - c1d_q;
    c3    = c2 - c2d_q;
    xd_d  = xd_q;
    c1d_d = c1d_q;
    c2d_d = c2d_q;
    c3_d  = c3_q;
    if (cen_q) begin
      xd_d  = x_ext;
      c1d_d = c1;
      c2d_d = c2;
      c3_d  = c3;
    end
    uen_d = cen_q;
  end

  // Zero-stuffed comb output drives the clk-rate integrator chain.
  always_comb begin
    u = '0;
    if (uen_q) begin
      u = {{(ACC_W-CW){c3_q[CW-1]}}, c3_q};
    end
    i1_d = i1_q + u;
    i2_d = i2_q + i1_q;
    i3_d = i3_q + i2_q;
    ysh  = i3_q >>> sh_eff;
    if (ysh > Y_MAX) begin
      y = Y_MAX[IN_W-1:0];
    end else if (ysh < Y_MIN) begin
      y = Y_MIN[IN_W-1:0];
    end else begin
      y = ysh[IN_W-1:0];
    end
    y_ext = {{(EW-IN_W){y[IN_W-1]}}, y};
    b     = ~e_q[EW-1];
    fb    = b ? FS_P : FS_N;
    e_d   = e_q + y_ext - fb;
    pdm_d = b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      r_q    <= '0;
      sh_q   <= '0;
      cfg_q  <= 1'b0;
      rdy_q  <= 1'b0;
      sclk_q <= 1'b0;
      und_q  <= 1'b0;
      cen_q  <= 1'b0;
      uen_q  <= 1'b0;
      pdm_q  <= 1'b0;
      x_q    <= '0;
      xd_q   <= '0;
      c1d_q  <= '0;
      c2d_q  <= '0;
      c3_q   <= '0;
      i1_q   <= '0;
      i2_q   <= '0;
      i3_q   <= '0;
      e_q    <= '0;
    end else begin
      cnt_q  <= cnt_d;
      r_q    <= r_d;
      sh_q   <= sh_d;
      cfg_q  <= cfg_d;
      rdy_q  <= rdy_d;
      sclk_q <= sclk_d;
      und_q  <= und_d;
      cen_q  <= cen_d;
      uen_q  <= uen_d;
      pdm_q  <= pdm_d;
      x_q    <= x_d;
      xd_q   <= xd_d;
      c1d_q  <= c1d_d;
      c2d_q  <= c2d_d;
      c3_q   <= c3_d;
      i1_q   <= i1_d;
      i2_q   <= i2_d;
      i3_q   <= i3_d;
      e_q    <= e_d;
    end
  end

  assign s_ready  = rdy_q;
  assign s_clk    = sclk_q;
  assign pdm_out  = pdm_q;
  assign underrun = und_q;

endmodule
